// File: rtl/accumulator_bank.sv
// accumulator_bank: multi-pass partial-sum accumulator for conv layers.
// Each beat adds up to NUMBER_OF_UNITS lane results to a start value for one
// output pixel. The start value is the latched bias on the first depth pass,
// otherwise the stored partial sum. Final-pass sums leave through out_* with
// the pixel address.
//
// Optional feature macro: ACCU_RELU_EN
//   When defined, a final sum with its MSB set is output as all-zero.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start              pulse: begin (or restart) an output map, samples data_bias
//   in_valid           beat qualifier for data_in_from_conv
//   data_in_from_conv  NUMBER_OF_UNITS lanes of DATA_WIDTH, lane 0 in the LSBs
//   data_bias          bias for the current filter
//   busy               high from start until done
//   out_valid          final pixel valid (out_addr, accu_data_out)
//   done               one-cycle pulse after the last final pixel
module accumulator_bank #(
    parameter int unsigned ARITH_TYPE            = 0,
    parameter int unsigned DATA_WIDTH            = 32,
    parameter int unsigned IFM_SIZE              = 14,
    parameter int unsigned KERNAL_SIZE           = 5,
    parameter int unsigned IFM_DEPTH             = 6,
    parameter int unsigned NUMBER_OF_UNITS       = 3,
    parameter int unsigned IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int unsigned NUM_PIXELS            = IFM_SIZE_NEXT * IFM_SIZE_NEXT,
    parameter int unsigned NUM_PASSES            = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
    parameter int unsigned LAST_LANES            = IFM_DEPTH - (NUM_PASSES - 1) * NUMBER_OF_UNITS,
    parameter int unsigned ADDRESS_SIZE_NEXT_IFM = $clog2(NUM_PIXELS)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic                                  in_valid,
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_in_from_conv,
    input  logic [DATA_WIDTH-1:0]                 data_bias,
    output logic                                  busy,
    output logic                                  out_valid,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0]      out_addr,
    output logic [DATA_WIDTH-1:0]                 accu_data_out,
    output logic                                  done
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDRESS_SIZE_NEXT_IFM;
    localparam int unsigned PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t          state;
    logic [AW-1:0]   pix_cnt;
    logic [PW-1:0]   pass_cnt;
    logic [DW-1:0]   bias_q;
    logic [DW-1:0]   psum_mem [NUM_PIXELS];
    logic [DW-1:0]   start_val;
    logic [DW-1:0]   sum;
    logic [DW-1:0]   result;
    logic            final_pass;
    logic            last_pix;
    logic            beat;

    assign final_pass = (pass_cnt == PW'(NUM_PASSES - 1));
    assign last_pix   = (pix_cnt == AW'(NUM_PIXELS - 1));
    assign beat       = (state == ACCUM) && in_valid && !start;
    assign start_val  = (pass_cnt == '0) ? bias_q : psum_mem[pix_cnt];

    // Adder chain; lanes beyond LAST_LANES are bypassed on the final pass so
    // they cannot disturb the sum (not even the sign of a float zero).
    for (genvar i = 0; i < int'(NUMBER_OF_UNITS); i++) begin : g_lane
        localparam bit IN_LAST = (i < int'(LAST_LANES));
        logic [DW-1:0] acc_in;
        logic [DW-1:0] add_y;
        logic [DW-1:0] acc_out;
        if (i == 0) begin : g_first
            assign acc_in = start_val;
        end else begin : g_next
            assign acc_in = g_lane[i-1].acc_out;
        end
        adder #(.ARITH_TYPE(ARITH_TYPE), .DATA_WIDTH(DW)) u_add (
            .a (acc_in),
            .b (data_in_from_conv[i*DW +: DW]),
            .y (add_y)
        );
        assign acc_out = (final_pass && !IN_LAST) ? acc_in : add_y;
    end
    assign sum = g_lane[NUMBER_OF_UNITS-1].acc_out;

`ifdef ACCU_RELU_EN
    assign result = sum[DW-1] ? '0 : sum;
`else
    assign result = sum;
`endif

    // Partial-sum storage; only intermediate passes write it.
    always_ff @(posedge clk) begin
        if (beat && !final_pass) begin
            psum_mem[pix_cnt] <= sum;
        end
    end

    // Control FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            pass_cnt      <= '0;
            bias_q        <= '0;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            accu_data_out <= '0;
            done          <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            if (start) begin
                // Start (or abort-and-restart) from any state; a coincident beat is dropped.
                bias_q   <= data_bias;
                pix_cnt  <= '0;
                pass_cnt <= '0;
                busy     <= 1'b1;
                state    <= ACCUM;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    ACCUM: begin
                        if (in_valid) begin
                            if (final_pass) begin
                                out_valid     <= 1'b1;
                                out_addr      <= pix_cnt;
                                accu_data_out <= result;
                            end
                            if (last_pix) begin
                                pix_cnt <= '0;
                                if (final_pass) begin
                                    state <= FLUSH;
                                end else begin
                                    pass_cnt <= pass_cnt + PW'(1);
                                end
                            end else begin
                                pix_cnt <= pix_cnt + AW'(1);
                            end
                        end
                    end
                    FLUSH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// adder: y = a + b. ARITH_TYPE 0 is a wrapping two's-complement add; 1 is an
// IEEE-754 binary32 add (round-to-nearest-even, subnormals flushed to zero).
module adder #(
    parameter int unsigned ARITH_TYPE = 0,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    if (ARITH_TYPE == 0) begin : g_int
        assign y = a + b;
    end else begin : g_fp
        logic              swap;
        logic [31:0]       x, z, res;
        logic [7:0]        d;
        logic [26:0]       mx, mz, lost;
        logic [27:0]       s;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic              rnd;
        logic [24:0]       mr;

        always_comb begin
            // x holds the larger magnitude so the mantissa difference is never negative.
            swap = (32'(b) & 32'h7FFF_FFFF) > (32'(a) & 32'h7FFF_FFFF);
            x    = swap ? 32'(b) : 32'(a);
            z    = swap ? 32'(a) : 32'(b);
            mx   = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
            mz   = (z[30:23] == 8'd0) ? 27'd0 : {1'b1, z[22:0], 3'b000};
            d    = x[30:23] - z[30:23];
            lost = '0;
            if (d > 8'd26) begin
                lost = mz;
                mz   = '0;
            end else begin
                lost = mz & ~(27'h7FF_FFFF << d);
                mz   = mz >> d;
            end
            mz[0] = mz[0] | (|lost);
            s = (x[31] == z[31]) ? ({1'b0, mx} + {1'b0, mz}) : ({1'b0, mx} - {1'b0, mz});
            e  = $signed({2'b00, x[30:23]});
            lz = '0;
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 10'sd1;
            end else begin
                for (int i = 0; i < 27; i++) begin
                    if (s[i]) lz = 5'(26 - i);
                end
                s = s << lz;
                e = e - $signed({5'd0, lz});
            end
            rnd = s[2] & (s[3] | s[1] | s[0]);
            mr  = {1'b0, s[26:3]} + 25'(rnd);
            if (mr[24]) e = e + 10'sd1;
            if (x[30:23] == 8'hFF) begin
                res = (z[30:23] == 8'hFF && x[31] != z[31]) ? 32'h7FC0_0000 : x;
            end else if (s == 28'd0) begin
                res = {x[31] & z[31], 31'd0};
            end else if (e >= 10'sd255) begin
                res = {x[31], 8'hFF, 23'd0};
            end else if (e <= 10'sd0) begin
                res = {x[31], 31'd0};
            end else begin
                res = {x[31], e[7:0], mr[22:0]};
            end
        end
        assign y = DATA_WIDTH'(res);
    end
endmodule
